// File: rtl/imem_loader.sv
// imem_loader: run-time byte-stream loader for the SEQ instruction store plus 80-bit fetch window.
// Define IMEM_CLEAR_EN to zero the whole store before every load.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  input  logic [63:0]       PC,
  output logic [0:79]       instr,
  output logic              imem_error,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    StIdle,
`ifdef IMEM_CLEAR_EN
    StClear,
`endif
    StLoad,
    StDone,
    StErr
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W:0]   MemSize  = (ADDR_W + 1)'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W:0]   rd_addr;
  logic [7:0]        mem [MEM_BYTES];
`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  assign ld_ready   = (state_q == StLoad);
  assign cpu_run    = (state_q == StDone);
  assign load_err   = (state_q == StErr);
  assign byte_count = count_q;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;
    mem_wdata = ld_data;
`ifdef IMEM_CLEAR_EN
    clr_d     = clr_q;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          wptr_d  = base_addr;
          count_d = '0;
`ifdef IMEM_CLEAR_EN
          clr_d   = '0;
          state_d = StClear;
`else
          state_d = StLoad;
`endif
        end
      end
`ifdef IMEM_CLEAR_EN
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = 8'h00;
        clr_d     = clr_q + 1'b1;
        if (clr_q == LastAddr) state_d = StLoad;
      end
`endif
      StLoad: begin
        if (ld_valid) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          // A last byte landing on the top address is a clean finish, not an overflow.
          if (ld_last) state_d = StDone;
          else if (wptr_q == LastAddr) state_d = StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      count_q <= '0;
`ifdef IMEM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
`ifdef IMEM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Store contents survive reset so a half-loaded image stays visible.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    instr      = '0;
    rd_addr    = '0;
    imem_error = (PC >= 64'(MEM_BYTES));
    if (!imem_error) begin
      for (int k = 0; k < 10; k++) begin
        rd_addr = PC[ADDR_W:0] + (ADDR_W + 1)'(k);
        if (rd_addr < MemSize) instr[8*k +: 8] = mem[rd_addr[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; define IMEM_CLEAR_EN to match the RTL build.
module tb_imem_loader;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, ld_ready, ld_last;
  logic [9:0]  base_addr;
  logic [7:0]  ld_data;
  logic [63:0] PC;
  logic [0:79] instr;
  logic        imem_error, cpu_run, load_err;
  logic [10:0] byte_count;

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .PC(PC), .instr(instr), .imem_error(imem_error), .cpu_run(cpu_run),
    .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run, err, rdy;
    logic [10:0] cnt;
  } st_t;

  typedef struct {
    logic [63:0] pc;
    logic [79:0] data;
    logic        err;
  } rd_t;

  st_t        st_q[$];
  rd_t        rd_q[$];
  st_t        s_mon;
  rd_t        r_mon;
  logic [7:0] model [MB];
  int         total = 0;
  int         bad = 0;
  logic       rd_req = 1'b0;
  logic       st_req = 1'b0;
  logic       done_prev = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input string name, input logic run, input logic err, input logic rdy,
                         input int cnt);
    st_t s;
    s.name = name; s.run = run; s.err = err; s.rdy = rdy; s.cnt = 11'(cnt);
    st_q.push_back(s);
  endtask

  task automatic status_now(input string name, input logic run, input logic err, input logic rdy,
                            input int cnt);
    push_st(name, run, err, rdy, cnt);
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 16 && st_q.size() != 0; c++) tick();
    if (st_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s completion: missing, expected run=%0b err=%0b cnt=%0d",
               name, st_q[0].run, st_q[0].err, st_q[0].cnt);
      st_q.delete();
    end
  endtask

  // Start a load; ld_valid is also driven during the start cycle and must be ignored.
  task automatic do_start(input int base);
    start = 1'b1; base_addr = 10'(base);
    ld_valid = 1'b1; ld_data = 8'($urandom); ld_last = 1'($urandom);
    tick();
    start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
`ifdef IMEM_CLEAR_EN
    begin
      int k;
      k = 1;
      while (!ld_ready && k < 1200) begin
        tick();
        k++;
      end
      check("clear_latency", 80'(k), 80'd1025);
      for (int i = 0; i < MB; i++) model[i] = 8'h00;
    end
`endif
    status_now("restart", 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic load(input int base, input logic [7:0] d[$], input bit thr, input bit last,
                      input string name);
    int n;
    bit fin;
    n = d.size();
    fin = 1'b0;
    for (int i = 0; i < n; i++) begin
      model[base + i] = d[i];
      if (last && i == n - 1) begin
        push_st(name, 1'b1, 1'b0, 1'b0, i + 1); fin = 1'b1; break;
      end
      if (base + i == MB - 1) begin
        push_st(name, 1'b0, 1'b1, 1'b0, i + 1); fin = 1'b1; break;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (thr) begin
        ld_valid = 1'b0; ld_data = 8'($urandom); ld_last = 1'($urandom);
        tick();
      end
      ld_valid = 1'b1; ld_data = d[i]; ld_last = last && (i == n - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    if (fin) drain(name);
  endtask

  task automatic fetch(input logic [63:0] pc);
    rd_t r;
    r.pc = pc;
    r.err = (pc >= 64'(MB));
    r.data = '0;
    for (int k = 0; k < 10; k++) begin
      r.data = r.data << 8;
      if (!r.err && pc + 64'(k) < 64'(MB)) r.data[7:0] = model[int'(pc) + k];
    end
    rd_q.push_back(r);
    PC = pc; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL fetch: no expectation queued");
      end else begin
        r_mon = rd_q.pop_front();
        check($sformatf("instr pc=%0h", r_mon.pc), instr, r_mon.data);
        check($sformatf("imem_error pc=%0h", r_mon.pc), 80'(imem_error), 80'(r_mon.err));
      end
    end
    if (st_req || ((cpu_run || load_err) && !done_prev)) begin
      if (st_q.size() == 0) begin
        total++; bad++;
        $display("FAIL status: unexpected run=%0b err=%0b cnt=%0d", cpu_run, load_err,
                 byte_count);
      end else begin
        s_mon = st_q.pop_front();
        check({s_mon.name, " status"}, 80'({cpu_run, load_err, ld_ready, byte_count}),
              80'({s_mon.run, s_mon.err, s_mon.rdy, s_mon.cnt}));
      end
    end
    done_prev <= cpu_run || load_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    reset = 1'b1; start = 1'b0; base_addr = '0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; PC = '0;
    repeat (2) @(posedge clk);
    #1;
    status_now("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick();

    // Fill the whole store so every model byte is known; last byte lands on 1023.
    d.delete();
    for (int i = 0; i < MB; i++) d.push_back(8'($urandom));
    do_start(0);
    load(0, d, 1'b0, 1'b1, "full");
    fetch(0); fetch(1019); fetch(1023);

    d = '{8'h10, 8'h22, 8'hBC, 8'h30, 8'hF2, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00};
    do_start(0);
    load(0, d, 1'b0, 1'b1, "prog13");
    fetch(3); fetch(0);

    d = '{8'hA0, 8'h0F, 8'hB0, 8'h5F};
    do_start(54);
    load(54, d, 1'b1, 1'b1, "throttled");
    fetch(54); fetch(52);

    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_start(1020);
    load(1020, d, 1'b0, 1'b1, "overflow");
    fetch(0); fetch(1020);

    d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_start(1020);
    load(1020, d, 1'b0, 1'b1, "top4");
    fetch(1020); fetch(1015); fetch(1024);
    fetch(64'h0000_0001_0000_0000); fetch(64'hFFFF_FFFF_FFFF_FFFC);

    // Reset three bytes into a ten-byte load, then reload.
    d.delete();
    for (int i = 0; i < 3; i++) d.push_back(8'($urandom));
    do_start(200);
    load(200, d, 1'b0, 1'b0, "partial");
    reset = 1'b1;
    #1;
    check("reset_ready_immediate", 80'(ld_ready), 80'd0);
    status_now("mid_reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick();
    fetch(199);
    d.delete();
    for (int i = 0; i < 10; i++) d.push_back(8'($urandom));
    do_start(200);
    load(200, d, 1'b0, 1'b1, "reload");
    fetch(200); fetch(205);

    for (int it = 0; it < 8; it++) begin
      int base, n;
      base = $urandom_range(0, MB - 1);
      n = $urandom_range(1, 24);
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      do_start(base);
      load(base, d, 1'($urandom), 1'b1, $sformatf("rand%0d", it));
      fetch(64'(base));
      for (int j = 0; j < 3; j++) fetch(64'($urandom_range(0, MB + 8)));
    end

`ifdef IMEM_CLEAR_EN
    d.delete();
    for (int i = 0; i < MB; i++) d.push_back(8'hFF);
    do_start(0);
    load(0, d, 1'b0, 1'b1, "all_ff");
    d = '{8'h00};
    do_start(0);
    load(0, d, 1'b0, 1'b1, "one_zero");
    fetch(0); fetch(500); fetch(1014); fetch(1020);
`endif

    drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
